text_rasterizer: RTL
====================

// Module: text_rasterizer
// PURPOSE
//   Reads glyph bitmaps out of bitmap_rom and serialises a line of LINE_LEN characters
//   into a raster-ordered 1-bit pixel stream: rows top-to-bottom, within a row
//   characters left-to-right, within a character cols left-to-right.
//   Drives the ROM lookup port (char/row/col -> dot); feeds the display pixel sink over valid/ready.
// PARAMETERS
//   ADDR_WIDTH  5   char code width; must match bitmap_rom ADDR_WIDTH
//   LINE_LEN    8   characters per line buffer (>=2)
//   NUM_GLYPHS  30  codes >= NUM_GLYPHS are blank; ROM dot ignored, pixel forced 0
// PORTS
//   clk        in   1                    clock
//   rst_n      in   1                    async active-low reset
//   wr_en      in   1                    write line-buffer entry
//   wr_idx     in   $clog2(LINE_LEN)     entry index
//   wr_char    in   ADDR_WIDTH           char code to store
//   start      in   1                    begin scan of current buffer
//   busy       out  1                    scan in progress
//   done       out  1                    1-cycle pulse, scan finished
//   rom_char   out  ADDR_WIDTH           to bitmap_rom.char
//   rom_row    out  3                    to bitmap_rom.row (0 = top)
//   rom_col    out  3                    to bitmap_rom.col (0 = leftmost)
//   rom_dot    in   1                    from bitmap_rom.dot (combinational)
//   pix_valid  out  1                    pixel beat valid
//   pix_ready  in   1                    sink accepts beat
//   pix_dot    out  1                    pixel value
//   pix_eol    out  1                    beat is last pixel of a row
//   pix_eof    out  1                    beat is last pixel of the scan
// BEHAVIOUR
// - Reset: FSM=IDLE, busy=0, done=0, pix_valid=0, pix_dot/eol/eof=0, counters=0,
//   all buffer entries = all-ones code (blank). Reset mid-scan aborts; no further beats.
// - FSM IDLE -> SCAN on start=1 in IDLE; start in SCAN ignored. SCAN -> DRAIN when
//   the final address (row 7, char LINE_LEN-1, col 7) is loaded into the output reg;
//   DRAIN -> IDLE when that beat handshakes. busy=1 in SCAN and DRAIN.
// - Writes: accepted only in IDLE; wr_en in SCAN/DRAIN dropped; wr_idx>=LINE_LEN dropped.
//   wr_en and start in the same IDLE cycle: write lands, scan uses the new value.
// - Address counters (row,chr,col): col fastest, then chr, then row. rom_char = buf[chr],
//   rom_row = row, rom_col = col, driven from counters in every state (0 in IDLE).
// - Output reg loads when SCAN and (!pix_valid || pix_ready): pix_dot =
//   (buf[chr] < NUM_GLYPHS) ? rom_dot : 0; pix_eol = (chr==LINE_LEN-1 && col==7);
//   pix_eof = pix_eol && row==7; counters advance on every load.
// - First pix_valid exactly 1 cycle after start accepted. While pix_valid && !pix_ready,
//   pix_dot/eol/eof held stable and counters frozen. pix_valid drops only after handshake
//   with no new load. With pix_ready tied 1: one beat per cycle, no bubbles.
// - Beats per scan = 64*LINE_LEN; eol every 8*LINE_LEN beats; exactly one eof.
// - done pulses in the cycle after the eof handshake; busy=0 in that same cycle, so a
//   start there is accepted (back-to-back scans).
// TESTING
// - Reset, buf[0]=1 ('1'), rest blank, start, ready=1 -> first row: beat col3=1, all
//   other 63 beats 0; row1 dots at cols 2,3; 512 beats total.
// - Count markers, LINE_LEN=8 -> pix_eol on beats 63,127,...,511; pix_eof only on 511;
//   done 1 cycle after beat 511; busy low same cycle.
// - Random pix_ready backpressure -> beat sequence identical to ready=1 run;
//   outputs stable while stalled.
// - wr_en during busy, wr_idx=LINE_LEN, start during busy -> buffer/scan unaffected.
// - Code 31 (>= NUM_GLYPHS) with rom_dot forced 1 -> all its pixels 0.
// - rst_n low mid-scan -> pix_valid=0, busy=0 immediately; new start gives full 512 beats.

Source files
------------

// File: rtl/text_rasterizer.sv
// Line-buffer text rasterizer: walks row/char/col over LINE_LEN glyphs, looks
// each dot up in an external bitmap ROM and streams raster-ordered pixels over valid/ready.
module text_rasterizer #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned LINE_LEN   = 8,
   parameter int unsigned NUM_GLYPHS = 30
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [$clog2(LINE_LEN)-1:0] wr_idx,
   input  logic [ADDR_WIDTH-1:0]       wr_char,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [ADDR_WIDTH-1:0]       rom_char,
   output logic [2:0]                  rom_row,
   output logic [2:0]                  rom_col,
   input  logic                        rom_dot,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic                        pix_dot,
   output logic                        pix_eol,
   output logic                        pix_eof
);

   localparam int unsigned IW = $clog2(LINE_LEN);
   localparam logic [IW-1:0] LAST_CHR = IW'(LINE_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] buf_q [LINE_LEN];
   logic [2:0]            row_q, row_d;
   logic [2:0]            col_q, col_d;
   logic [IW-1:0]         chr_q, chr_d;
   logic                  pix_valid_q, pix_valid_d;
   logic                  dot_q, dot_d;
   logic                  eol_q, eol_d;
   logic                  eof_q, eof_d;
   logic                  done_q, done_d;
   logic                  load;
   logic                  at_eol;
   logic                  blank;
   logic                  wr_ok;
   logic [ADDR_WIDTH-1:0] cur_char;

   assign cur_char = buf_q[chr_q];

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      chr_d       = chr_q;
      col_d       = col_q;
      pix_valid_d = pix_valid_q;
      dot_d       = dot_q;
      eol_d       = eol_q;
      eof_d       = eof_q;
      done_d      = 1'b0;
      load        = (state_q == SCAN) && (!pix_valid_q || pix_ready);
      at_eol      = (chr_q == LAST_CHR) && (col_q == 3'd7);
      blank       = !(32'(cur_char) < NUM_GLYPHS);
      wr_ok       = (state_q == IDLE) && wr_en;

      if (load) begin
         pix_valid_d = 1'b1;
         dot_d       = blank ? 1'b0 : rom_dot;
         eol_d       = at_eol;
         eof_d       = at_eol && (row_q == 3'd7);
         col_d       = col_q + 3'd1;
         if (col_q == 3'd7) begin
            if (chr_q == LAST_CHR) begin
               chr_d = '0;
               row_d = row_q + 3'd1;
            end else begin
               chr_d = chr_q + IW'(1);
            end
         end
      end else if (pix_valid_q && pix_ready) begin
         pix_valid_d = 1'b0;
         dot_d       = 1'b0;
         eol_d       = 1'b0;
         eof_d       = 1'b0;
      end

      // DRAIN only waits for the final beat to be taken; counters already wrapped to 0
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (load && at_eol && (row_q == 3'd7)) state_d = DRAIN;
         DRAIN:   if (pix_ready) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LINE_LEN; i++) buf_q[i] <= '1;
      end else if (wr_ok) begin
         for (int unsigned i = 0; i < LINE_LEN; i++) begin
            if (wr_idx == IW'(i)) buf_q[i] <= wr_char;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         chr_q       <= '0;
         col_q       <= '0;
         pix_valid_q <= 1'b0;
         dot_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         chr_q       <= chr_d;
         col_q       <= col_d;
         pix_valid_q <= pix_valid_d;
         dot_q       <= dot_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign rom_char  = cur_char;
   assign rom_row   = row_q;
   assign rom_col   = col_q;
   assign pix_valid = pix_valid_q;
   assign pix_dot   = dot_q;
   assign pix_eol   = eol_q;
   assign pix_eof   = eof_q;

endmodule
